// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// byte-enable patterns and request legality helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Unsigned variants exist only for loads; stores accept B/H/W.
    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        logic legal;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !write;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = (offset != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and data-memory handshake of the load/store unit.
// master: the LSU itself; slave: the core/memory environment around it.
interface lsu_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        bus_err;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  req_valid, req_write, funct3, addr, wdata, mem_rdata, mem_ack,
        output stall, resp_valid, rdata, bus_err, misalign,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_write, funct3, addr, wdata, mem_rdata, mem_ack,
        input  stall, resp_valid, rdata, bus_err, misalign,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication,
// load lane selection with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = mem_rdata[{offset, 3'b000} +: 8];
    assign half_lane = mem_rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        be         = '0;
        store_data = '0;
        load_data  = '0;
        case (funct3)
            F3_B, F3_BU: begin
                be         = BE_BYTE << offset;
                store_data = {4{wdata[7:0]}};
                load_data  = (funct3 == F3_B) ? {{24{byte_lane[7]}}, byte_lane}
                                              : {24'h0, byte_lane};
            end
            // Halves ignore offset[0]: either trapped upstream or deliberately rounded down.
            F3_H, F3_HU: begin
                be         = BE_HALF << {offset[1], 1'b0};
                store_data = {2{wdata[15:0]}};
                load_data  = (funct3 == F3_H) ? {{16{half_lane[15]}}, half_lane}
                                              : {16'h0, half_lane};
            end
            F3_W: begin
                be         = BE_WORD;
                store_data = wdata;
                load_data  = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding memory handshake that stalls the core until done.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.master bus
);
    localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [2:0]       funct3_q;
    logic             write_q, err_q;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic             accept, ack_hit, timeout_hit;
    logic             in_idle, in_access, in_done;
    logic             req_illegal, req_misalign, req_fault;
    logic [3:0]       be;
    logic [31:0]      store_data, load_data;

    assign req_illegal = !funct3_legal(bus.req_write, bus.funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign req_misalign = !req_illegal && is_misaligned(bus.funct3, bus.addr[1:0]);
`else
    assign req_misalign = 1'b0;
`endif
    assign req_fault = req_illegal || req_misalign;
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = req_fault ? ST_DONE : ST_ACCESS;
                end
            end
            // An ACK arriving on the timeout cycle still completes normally.
            ST_ACCESS: begin
                if (bus.mem_ack) begin
                    ack_hit = 1'b1;
                    state_d = ST_DONE;
                end else if (TIMEOUT_EN && (cnt_inc == TIMEOUT_VAL)) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            err_q <= req_illegal;
        end else begin
            if (in_access)   cnt_q <= cnt_inc;
            if (timeout_hit) err_q <= 1'b1;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)         misalign_q <= 1'b0;
        else if (accept) misalign_q <= req_misalign;
    end
    assign bus.misalign = in_done && misalign_q;
`else
    assign bus.misalign = 1'b0;
`endif

    // NOTE: request/response datapath has no reset: the FSM loads it before anything reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
            funct3_q <= bus.funct3;
            write_q  <= bus.req_write;
            rdata_q  <= '0;
        end else if (ack_hit) begin
            rdata_q  <= write_q ? '0 : load_data;
        end
    end

    lsu_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .wdata      (wdata_q),
        .mem_rdata  (bus.mem_rdata),
        .be         (be),
        .store_data (store_data),
        .load_data  (load_data)
    );

    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);
    assign in_done   = (state_q == ST_DONE);

    assign bus.stall      = (in_idle && bus.req_valid) || in_access;
    assign bus.resp_valid = in_done;
    assign bus.bus_err    = in_done && err_q;
    assign bus.rdata      = in_done ? rdata_q : '0;

    assign bus.mem_req   = in_access;
    assign bus.mem_we    = in_access && write_q;
    assign bus.mem_addr  = in_access ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_be    = in_access ? be : '0;
    assign bus.mem_wdata = (in_access && write_q) ? store_data : '0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed corner cases plus randomized transactions
// compared against a behavioural model of the access rules.
module tb_lsu;
    import lsu_pkg::*;

    localparam int unsigned TIMEOUT = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    lsu_if bus ();

    lsu #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          fault;
        bit          illegal;
        bit          mis;
        bit          timeout;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          access;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic string tag(input int id, input string s);
        return $sformatf("t%0d_%s", id, s);
    endfunction

    function automatic exp_t model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd, input int delay);
        exp_t        e;
        int          size, off, eoff, bits;
        bit          sgn;
        logic [31:0] mask, v;
        size = 0;
        sgn  = 1'b0;
        case (f3)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: size = 4;
            3'b100: size = 1;
            3'b101: size = 2;
            default: size = 0;
        endcase
        e.illegal = (size == 0) || (wr && f3[2]);
        off = int'(a[1:0]);
        if (!e.illegal && TRAP) e.mis = ((off % size) != 0);
        else                    e.mis = 1'b0;
        e.fault   = e.illegal || e.mis;
        e.timeout = !e.fault && (delay >= int'(TIMEOUT));
        eoff = (size != 0) ? off - (off % size) : 0;
        bits = 8 * size;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        e.addr = a & 32'hFFFF_FFFC;
        e.be   = 4'(((1 << size) - 1) << eoff);
        case (size)
            1:       e.wdata = 32'(wd[7:0]) * 32'h0101_0101;
            2:       e.wdata = 32'(wd[15:0]) * 32'h0001_0001;
            default: e.wdata = wd;
        endcase
        v = (rd >> (8 * eoff)) & mask;
        if (sgn && size < 4 && v[bits-1]) v = v | ~mask;
        e.rdata  = (e.fault || e.timeout || wr) ? 32'h0 : v;
        e.access = e.fault ? 0 : (e.timeout ? int'(TIMEOUT) : delay + 1);
        return e;
    endfunction

    // delay = ACCESS cycles without ACK before the ACK cycle.
    task automatic run_txn(input int id, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int delay);
        exp_t e;
        int   stalls;
        int   k;
        bit   fin;
        e      = model(wr, f3, a, wd, rd, delay);
        stalls = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.mem_ack   = 1'b0;
        #1;
        if (bus.stall === 1'b1) stalls++;
        check(tag(id, "req_mem_req"), bus.mem_req, 1'b0);
        @(negedge clk);
        // Scramble request inputs: the LSU must work from its latched copy.
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.funct3    = 3'($urandom);
        bus.addr      = $urandom;
        bus.wdata     = $urandom;
        if (!e.fault) begin
            k   = 1;
            fin = 1'b0;
            while (!fin) begin
                bus.mem_ack   = (k == delay + 1);
                bus.mem_rdata = bus.mem_ack ? rd : $urandom;
                #1;
                if (bus.stall === 1'b1) stalls++;
                check(tag(id, "acc_mem_req"), bus.mem_req, 1'b1);
                if (k == 1) begin
                    check(tag(id, "mem_addr"), bus.mem_addr, e.addr);
                    check(tag(id, "mem_be"), bus.mem_be, e.be);
                    check(tag(id, "mem_we"), bus.mem_we, wr);
                    if (wr) check(tag(id, "mem_wdata"), bus.mem_wdata, e.wdata);
                end
                if (bus.mem_ack || k >= int'(TIMEOUT)) fin = 1'b1;
                else begin
                    k++;
                    @(negedge clk);
                end
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        bus.req_valid = 1'($urandom);
        #1;
        if (bus.stall === 1'b1) stalls++;
        check(tag(id, "resp_valid"), bus.resp_valid, 1'b1);
        check(tag(id, "rdata"), bus.rdata, e.rdata);
        check(tag(id, "bus_err"), bus.bus_err, e.illegal || e.timeout);
        check(tag(id, "misalign"), bus.misalign, e.mis);
        check(tag(id, "done_mem_req"), bus.mem_req, 1'b0);
        check(tag(id, "stall_cycles"), stalls, e.access + 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'($urandom);
        #1;
        check(tag(id, "idle_resp_valid"), bus.resp_valid, 1'b0);
        check(tag(id, "idle_mem_req"), bus.mem_req, 1'b0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        check(tag(id, "post_resp_valid"), bus.resp_valid, 1'b0);
        check(tag(id, "post_mem_req"), bus.mem_req, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.funct3    = 3'b000;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", bus.stall, 1'b0);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_bus_err", bus.bus_err, 1'b0);
        check("rst_misalign", bus.misalign, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_be", bus.mem_be, 4'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        bus.req_valid = 1'b1;
        #1;
        check("rst_stall_req", bus.stall, 1'b1);
        @(negedge clk);
        #1;
        check("rst_hold_mem_req", bus.mem_req, 1'b0);
        bus.req_valid = 1'b0;
        rst           = 1'b0;

        run_txn(0, 1'b0, F3_W,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2);
        run_txn(1, 1'b0, F3_B,  32'h0000_0203, 32'h0,         32'h8012_3456, 0);
        run_txn(2, 1'b0, F3_BU, 32'h0000_0203, 32'h0,         32'h8012_3456, 1);
        run_txn(3, 1'b1, F3_H,  32'h0000_0102, 32'h1234_ABCD, 32'h0,         0);
        run_txn(4, 1'b0, F3_W,  32'h0000_0101, 32'h0,         32'hCAFE_F00D, 0);
        run_txn(5, 1'b0, F3_W,  32'h0000_0300, 32'h0,         32'h1234_5678, 9);
        run_txn(6, 1'b0, F3_W,  32'h0000_0304, 32'h0,         32'h0BAD_BEEF, 3);
        run_txn(7, 1'b0, 3'b011, 32'h0000_0400, 32'h0,        32'h5555_AAAA, 0);
        run_txn(8, 1'b1, F3_BU, 32'h0000_0404, 32'h77,        32'h0,         0);
        run_txn(9, 1'b1, 3'b111, 32'h0000_0408, 32'h77,       32'h0,         0);
        run_txn(10, 1'b1, F3_B, 32'h0000_0003, 32'h0000_00A5, 32'h0,         1);
        run_txn(11, 1'b0, F3_HU, 32'h0000_0006, 32'h0,        32'h9ABC_1234, 0);
        run_txn(12, 1'b0, F3_H,  32'h0000_0006, 32'h0,        32'h9ABC_1234, 0);

        // Reset in the middle of an access; a late ACK must not produce a response.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.funct3    = F3_W;
        bus.addr      = 32'h0000_0040;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        check("rst_mid_pre_mem_req", bus.mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_mem_req", bus.mem_req, 1'b0);
        check("rst_mid_stall", bus.stall, 1'b0);
        check("rst_mid_resp_valid", bus.resp_valid, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1111_2222;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        check("late_ack_resp_valid", bus.resp_valid, 1'b0);
        check("late_ack_mem_req", bus.mem_req, 1'b0);
        run_txn(13, 1'b0, F3_W, 32'h0000_0040, 32'h0, 32'h3333_4444, 1);

        for (int i = 0; i < 120; i++) begin
            run_txn(100 + i, 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
